// File: rtl/if_id_pkg.sv
// Shared definitions for the fetch-to-decode prefetch queue.
package if_id_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int DEPTH_DEFAULT = 4;

    // One buffered fetch result: the PC+4 value and the fetched instruction word.
    typedef struct packed {
        logic [WIDTH_DEFAULT-1:0] pc;
        logic [WIDTH_DEFAULT-1:0] instr;
    } if_entry_t;

    // All-zero word is the pipeline NOP; decode sees it whenever the queue is empty.
    localparam logic [WIDTH_DEFAULT-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_queue_mem.sv
// Register file backing the prefetch queue: one synchronous write port and
// one combinational read port. Contents are never reset; the queue's count
// decides which entries are meaningful.
module if_queue_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Capture the incoming entry at the write pointer when the queue accepts a push.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/if_id_queue.sv
// Instruction prefetch queue between fetch and decode. Fetch results are
// buffered in a small FIFO; fetch is frozen only when the FIFO is full, and a
// taken branch discards everything buffered. Decode pops with valid/ready.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_instr,
    input  logic             flush,
    output logic             freeze,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_instr,
    input  logic             out_ready
);

    // DEPTH must be a power of two so the pointers wrap by natural overflow.
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]      r_wrPtr;
    logic [AW-1:0]      r_rdPtr;
    logic [CW-1:0]      r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_rdData;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Freeze looks only at occupancy: a pop in the same cycle does not make
    // room for a push, which keeps the fetch-side path free of out_ready.
    assign w_push = in_valid && !w_full && !flush;
    assign w_pop  = out_valid && out_ready && !flush;

    assign freeze    = w_full;
    assign out_valid = !w_empty;

    // Present the head entry, or a NOP with a zero PC when nothing is buffered.
    assign out_pc    = w_empty ? '0 : w_rdData[2*WIDTH-1:WIDTH];
    assign out_instr = w_empty ? WIDTH'(NOP_INSTR) : w_rdData[WIDTH-1:0];

    if_queue_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH),
        .ADDR_W (AW)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_push),
        .i_wrAddr (r_wrPtr),
        .i_wrData ({in_pc, in_instr}),
        .i_rdAddr (r_rdPtr),
        .o_rdData (w_rdData)
    );

    // Pointer and occupancy bookkeeping; a flush empties the queue ahead of any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_if_id_queue;
    import if_id_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInstr;
    logic        flush;
    logic        freeze;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic        outReady;

    int total = 0;
    int bad   = 0;

    // Reference model: the buffered entries in order, head at index 0.
    if_entry_t model[$];

    typedef struct {
        logic        inValid;
        logic [31:0] inPc;
        logic [31:0] inInstr;
        logic        flush;
        logic        outReady;
        logic        expValid;
        logic [31:0] expPc;
        logic [31:0] expInstr;
        logic        expFreeze;
    } vec_t;

    vec_t vecs[$];

    if_id_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_pc     (inPc),
        .in_instr  (inInstr),
        .flush     (flush),
        .freeze    (freeze),
        .out_valid (outValid),
        .out_pc    (outPc),
        .out_instr (outInstr),
        .out_ready (outReady)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic eValid, input logic [31:0] ePc,
                               input logic [31:0] eInstr, input logic eFreeze);
        check({tag, ".valid"},  {31'b0, outValid}, {31'b0, eValid});
        check({tag, ".pc"},     outPc, ePc);
        check({tag, ".instr"},  outInstr, eInstr);
        check({tag, ".freeze"}, {31'b0, freeze}, {31'b0, eFreeze});
    endtask

    task automatic checkModel(input string tag);
        if (model.size() > 0) begin
            checkOutput(tag, 1'b1, model[0].pc, model[0].instr, model.size() == DEPTH);
        end else begin
            checkOutput(tag, 1'b0, 32'h0, 32'h0, 1'b0);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the queue's rules, then
    // step past the clock edge so outputs can be sampled mid-cycle.
    task automatic applyStimulus(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic fl, input logic rdy);
        bit wasFull;
        bit wasEmpty;
        inValid  = iv;
        inPc     = pc;
        inInstr  = instr;
        flush    = fl;
        outReady = rdy;
        wasFull  = (model.size() == DEPTH);
        wasEmpty = (model.size() == 0);
        if (fl) begin
            model.delete();
        end else begin
            if (rdy && !wasEmpty) begin
                void'(model.pop_front());
            end
            if (iv && !wasFull) begin
                model.push_back('{pc: pc, instr: instr});
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                                   input logic fl, input logic rdy, input logic eV,
                                   input logic [31:0] ePc, input logic [31:0] eInstr, input logic eF);
        vec_t v;
        v.inValid   = iv;
        v.inPc      = pc;
        v.inInstr   = instr;
        v.flush     = fl;
        v.outReady  = rdy;
        v.expValid  = eV;
        v.expPc     = ePc;
        v.expInstr  = eInstr;
        v.expFreeze = eF;
        return v;
    endfunction

    // Main sequence: reset, directed table, corner sequences, random run.
    initial begin
        rst      = 1'b0;
        inValid  = 1'b0;
        inPc     = '0;
        inInstr  = '0;
        flush    = 1'b0;
        outReady = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("inReset", 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("idle", 1'b0, 32'h0, 32'h0, 1'b0);

        // Fill to full, drop a push while full, then drain in order.
        vecs.push_back(mkVec(1, 32'd4,  32'hE3A01001, 0, 0, 1, 32'd4,  32'hE3A01001, 0));
        vecs.push_back(mkVec(1, 32'd8,  32'hE3A01002, 0, 0, 1, 32'd4,  32'hE3A01001, 0));
        vecs.push_back(mkVec(1, 32'd12, 32'hE3A01003, 0, 0, 1, 32'd4,  32'hE3A01001, 0));
        vecs.push_back(mkVec(1, 32'd16, 32'hE3A01004, 0, 0, 1, 32'd4,  32'hE3A01001, 1));
        vecs.push_back(mkVec(1, 32'd20, 32'hE3A01005, 0, 0, 1, 32'd4,  32'hE3A01001, 1));
        vecs.push_back(mkVec(0, 32'd0,  32'h0,        0, 1, 1, 32'd8,  32'hE3A01002, 0));
        vecs.push_back(mkVec(0, 32'd0,  32'h0,        0, 1, 1, 32'd12, 32'hE3A01003, 0));
        vecs.push_back(mkVec(0, 32'd0,  32'h0,        0, 1, 1, 32'd16, 32'hE3A01004, 0));
        vecs.push_back(mkVec(0, 32'd0,  32'h0,        0, 1, 0, 32'd0,  32'h0,        0));
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].inValid, vecs[i].inPc, vecs[i].inInstr, vecs[i].flush, vecs[i].outReady);
            checkOutput($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expPc,
                        vecs[i].expInstr, vecs[i].expFreeze);
        end

        // Streaming push+pop across pointer wrap: occupancy stays at one.
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b1, 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0, 1'b1);
            checkOutput($sformatf("stream%0d", k), 1'b1, 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("streamEnd", 1'b0, 32'h0, 32'h0, 1'b0);

        // Flush with a concurrent push and pop while holding three entries.
        applyStimulus(1'b1, 32'h10, 32'h11111111, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h14, 32'h22222222, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h18, 32'h33333333, 1'b0, 1'b0);
        checkOutput("pre3", 1'b1, 32'h10, 32'h11111111, 1'b0);
        applyStimulus(1'b1, 32'h1C, 32'h44444444, 1'b1, 1'b1);
        checkOutput("flush", 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("postFlush", 1'b0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h100, 32'h55555555, 1'b0, 1'b0);
        checkOutput("firstAfterFlush", 1'b1, 32'h100, 32'h55555555, 1'b0);

        // Flush while full releases freeze on the next cycle.
        applyStimulus(1'b1, 32'h104, 32'h66666666, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h108, 32'h77777777, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h10C, 32'h88888888, 1'b0, 1'b0);
        checkOutput("fullAgain", 1'b1, 32'h100, 32'h55555555, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flushFull", 1'b0, 32'h0, 32'h0, 1'b0);

        // Asynchronous reset between edges while two entries are held.
        applyStimulus(1'b1, 32'h200, 32'h99999999, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h204, 32'hAAAAAAAA, 1'b0, 1'b0);
        checkOutput("pre2", 1'b1, 32'h200, 32'h99999999, 1'b0);
        inValid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        checkOutput("asyncRst", 1'b0, 32'h0, 32'h0, 1'b0);
        model.delete();
        #2;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        checkOutput("afterRst", 1'b0, 32'h0, 32'h0, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus($urandom_range(99) < 70, $urandom, $urandom,
                          $urandom_range(99) < 5, $urandom_range(99) < 45);
            checkModel($sformatf("rand%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction prefetch queue sitting between the instruction-fetch stage and the decode stage: it is the receiving end of the fetch stage's PC/Instruction output. Each accepted fetch (PC+4 value and instruction word) is buffered in a small FIFO. The queue drives the fetch stage's freeze input when it cannot accept, and discards all buffered entries when a branch is taken. Decode pops entries with a valid/ready handshake, so decode stalls no longer propagate directly into fetch.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, at least 2
- WIDTH, 32, width of the PC and instruction fields

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch stage presents a fetched instruction this cycle
- in_pc  input  WIDTH  PC+4 value from the fetch stage
- in_instr  input  WIDTH  instruction word from the fetch stage
- flush  input  1  branch taken; discard all contents
- freeze  output  1  to the fetch stage; high means the current fetch is not accepted
- out_valid  output  1  the head entry is valid
- out_pc  output  WIDTH  PC field of the head entry
- out_instr  output  WIDTH  instruction field of the head entry
- out_ready  input  1  decode consumes the head entry this cycle

## Operation
- State: storage array of DEPTH entries {pc, instr}; wr_ptr and rd_ptr of width log2(DEPTH); count of width log2(DEPTH)+1.
- Derived signals: full = (count == DEPTH); empty = (count == 0).
- freeze = full, combinational from count. It does not depend on out_ready; a same-cycle pop does not open a slot for a same-cycle push.
- push = in_valid && !full && !flush.
- pop = out_valid && out_ready && !flush.
- Push: write {in_pc, in_instr} at wr_ptr, then wr_ptr increments.
- Pop: rd_ptr increments.
- Count rules:
  - push only: count +1
  - pop only: count −1
  - push and pop together: count unchanged
- Pointers wrap modulo DEPTH by natural overflow.
- out_valid = !empty.
- out_pc / out_instr = head entry when out_valid is high; forced to 0 when empty. All-zero is the pipeline NOP encoding.
- flush has priority over everything else: at the next edge count, wr_ptr and rd_ptr all go to 0. The concurrent push and pop are both suppressed. Storage contents are left unchanged and are don't-care.
- Pop while empty and push while full are no-ops. No error flag is raised.

## Timing
- Reset (rst low, asynchronous): count=0, wr_ptr=0, rd_ptr=0. Outputs: out_valid=0, out_pc=0, out_instr=0, freeze=0. Storage is not reset.
- Reset is released synchronously by the design's reset synchronizer. The first push is possible on the first edge with rst high.
- Reset asserted mid-operation clears all state immediately, independent of clk.
- Push-to-visible latency is 1 cycle: data pushed at edge N appears on out_* after edge N when the queue was empty.
- Head changes only at a clock edge; out_* is stable for the whole cycle.
- freeze rises in the cycle after the DEPTH-th push. It falls in the cycle after the first pop or flush.
- Flush at edge N: out_valid=0 and freeze=0 after edge N.
- Throughput: one push and one pop per cycle when 0 < count < DEPTH.

## Structure
- Shared package (if_id_pkg):
  - WIDTH_DEFAULT and DEPTH_DEFAULT constants
  - if_entry_t packed struct {pc, instr}
  - NOP_INSTR = 0
- One sub-module, if_queue_mem: DEPTH×(2·WIDTH) register file with one synchronous write port and one combinational read port. It has no reset. Pointer, count and control logic stay in if_id_queue.

## Test plan
- Reset then idle: hold rst low, release, no stimulus → out_valid=0, freeze=0, out_pc=0, out_instr=0.
- Fill: push pc=4,8,12,16 with instr=0xE3A01001..0xE3A01004 and out_ready=0 → freeze=1 after the 4th push; a 5th push (pc=20) is dropped; out_pc=4.
- Drain: from full, set out_ready=1 with in_valid=0 → out_pc sequence 4,8,12,16; out_valid=0 after 4 pops; freeze=0 after the first pop.
- Wrap and streaming: continuous push and pop for 12 cycles with pc=4·k → output order preserved across pointer wrap; count stays at 1.
- Flush with simultaneous events: with 3 entries, assert flush together with in_valid and out_ready → the next cycle shows out_valid=0 and count=0; the pushed entry never appears; the next push (pc=0x100) becomes the head after 1 cycle.
- Async reset mid-operation: assert rst low between edges while holding 2 entries → out_valid=0 and freeze=0 immediately, without waiting for a clock edge.
